// File: rtl/tt_pin_host.sv
// Byte-command host that drives a TinyTapeout-style DUT's pins and single-steps its clock.
// Define TT_PIN_HOST_ACK_EN to return a 0xA5 byte after writes, CTRL and completed STEPs.
module tt_pin_host #(
    parameter int STEP_MAX_LOG2 = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       dut_clk,
    output logic       dut_rst_n,
    output logic       dut_ena,
    output logic [7:0] ui_in,
    output logic [7:0] uio_in,
    input  logic [7:0] uo_out,
    input  logic [7:0] uio_out,
    input  logic [7:0] uio_oe
);

    localparam int CW = STEP_MAX_LOG2 + 1;

`ifdef TT_PIN_HOST_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    localparam logic [7:0] OP_WR_UI  = 8'h01;
    localparam logic [7:0] OP_WR_UIO = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_STEP   = 8'h04;
    localparam logic [7:0] OP_CTRL   = 8'h05;
    localparam logic [7:0] RSP_ACK   = 8'hA5;
    localparam logic [7:0] RSP_BAD   = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG,
        S_STEP_HI,
        S_STEP_LO,
        S_RSP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_cmd_fire;
    logic            w_rsp_fire;
    logic            w_two_byte;
    logic            w_last_pulse;
    logic [CW-1:0]   w_step_ld;
    logic [7:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_b0;
    logic [7:0]      r_b1;
    logic [7:0]      r_b2;
    logic [1:0]      r_left;
    logic            r_dut_clk;
    logic            r_dut_rst_n;
    logic            r_dut_ena;
    logic [7:0]      r_ui;
    logic [7:0]      r_uio;

    assign w_cmd_fire   = cmd_valid && cmd_ready;
    assign w_rsp_fire   = rsp_valid && rsp_ready;
    assign w_two_byte   = (cmd_data == OP_WR_UI) || (cmd_data == OP_WR_UIO)
                       || (cmd_data == OP_STEP)  || (cmd_data == OP_CTRL);
    assign w_last_pulse = (r_cnt == CW'(1));
    // An argument of zero means the full 2^STEP_MAX_LOG2 pulses.
    assign w_step_ld    = (cmd_data == 8'h00) ? {1'b1, {STEP_MAX_LOG2{1'b0}}}
                                              : CW'(cmd_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) w_next = w_two_byte ? S_ARG : S_RSP;
            end
            S_ARG: begin
                if (w_cmd_fire) begin
                    if (r_op == OP_STEP) w_next = S_STEP_HI;
                    else                 w_next = ACK_EN ? S_RSP : S_IDLE;
                end
            end
            S_STEP_HI: w_next = S_STEP_LO;
            S_STEP_LO: begin
                if (w_last_pulse) w_next = ACK_EN ? S_RSP : S_IDLE;
                else              w_next = S_STEP_HI;
            end
            S_RSP: begin
                if (w_rsp_fire && r_left == 2'd1) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = rst_n && (r_state == S_IDLE || r_state == S_ARG);
        rsp_valid = (r_state == S_RSP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= 8'h00;
            r_cnt       <= '0;
            r_b0        <= 8'h00;
            r_b1        <= 8'h00;
            r_b2        <= 8'h00;
            r_left      <= 2'd0;
            r_dut_clk   <= 1'b0;
            r_dut_rst_n <= 1'b0;
            r_dut_ena   <= 1'b0;
            r_ui        <= 8'h00;
            r_uio       <= 8'h00;
        end else begin
            r_dut_clk <= (w_next == S_STEP_HI);
            unique case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_op <= cmd_data;
                        if (cmd_data == OP_READ) begin
                            r_b0   <= uo_out;
                            r_b1   <= uio_out;
                            r_b2   <= uio_oe;
                            r_left <= 2'd3;
                        end else if (!w_two_byte) begin
                            r_b0   <= RSP_BAD;
                            r_left <= 2'd1;
                        end
                    end
                end
                S_ARG: begin
                    if (w_cmd_fire) begin
                        if (r_op == OP_WR_UI)  r_ui  <= cmd_data;
                        if (r_op == OP_WR_UIO) r_uio <= cmd_data;
                        if (r_op == OP_STEP)   r_cnt <= w_step_ld;
                        if (r_op == OP_CTRL) begin
                            r_dut_rst_n <= cmd_data[0];
                            r_dut_ena   <= cmd_data[1];
                        end
                        if (ACK_EN && r_op != OP_STEP) begin
                            r_b0   <= RSP_ACK;
                            r_left <= 2'd1;
                        end
                    end
                end
                S_STEP_LO: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (ACK_EN && w_last_pulse) begin
                        r_b0   <= RSP_ACK;
                        r_left <= 2'd1;
                    end
                end
                S_RSP: begin
                    if (w_rsp_fire) begin
                        r_b0   <= r_b1;
                        r_b1   <= r_b2;
                        r_b2   <= 8'h00;
                        r_left <= r_left - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data  = r_b0;
    assign dut_clk   = r_dut_clk;
    assign dut_rst_n = r_dut_rst_n;
    assign dut_ena   = r_dut_ena;
    assign ui_in     = r_ui;
    assign uio_in    = r_uio;

endmodule

// File: tb/tb_tt_pin_host.sv
// Directed bench for tt_pin_host: pin writes, READ backpressure, STEP pulse trains,
// unknown opcode and reset in the middle of a STEP.
module tb_tt_pin_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       dut_clk;
    logic       dut_rst_n;
    logic       dut_ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out = 8'h00;
    logic [7:0] uio_out = 8'h00;
    logic [7:0] uio_oe = 8'h00;

    int errs = 0;
    int checks = 0;

    tt_pin_host dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .dut_clk   (dut_clk),
        .dut_rst_n (dut_rst_n),
        .dut_ena   (dut_ena),
        .ui_in     (ui_in),
        .uio_in    (uio_in),
        .uo_out    (uo_out),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe)
    );

    always #5 clk = ~clk;

    // dut_clk pulse monitor, sampled on the falling edge of clk
    int   pulses = 0;
    int   hi_bad = 0;
    int   lo_bad = 0;
    int   lo_run = 0;
    logic prev = 1'b0;

    always @(negedge clk) begin
        if (dut_clk) begin
            if (!prev) begin
                pulses++;
                if (lo_run == 2) lo_bad++;
            end else begin
                hi_bad++;
            end
            lo_run = 0;
        end else begin
            lo_run++;
        end
        prev = dut_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("send_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [7:0] exp,
                        input int budget);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            chk({tag, "_timeout"}, 32'(rsp_valid), 32'd1);
            return;
        end
        chk(tag, 32'(rsp_data), 32'(exp));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(cmd_ready), 32'd1);
    endtask

    task automatic step_test(input string tag, input logic [7:0] arg,
                             input int exp_pulses);
        int p0 = pulses;
        int h0 = hi_bad;
        int l0 = lo_bad;
        send(8'h04);
        send(arg);
`ifdef TT_PIN_HOST_ACK_EN
        recv({tag, "_ack"}, 8'hA5, 4 * exp_pulses + 50);
`endif
        wait_idle({tag, "_idle"}, 4 * exp_pulses + 50);
        chk({tag, "_pulses"}, 32'(pulses - p0), 32'(exp_pulses));
        chk({tag, "_hi1"}, 32'(hi_bad - h0), 32'd0);
        chk({tag, "_lo1"}, 32'(lo_bad - l0), 32'd0);
    endtask

    initial begin
        logic stable;
        int   hi_seen;
        int   n;
        int   p1;
        int   seen;

        repeat (3) @(negedge clk);
        chk("rst_ctl", {27'd0, cmd_ready, rsp_valid, dut_clk, dut_rst_n, dut_ena}, 32'd0);
        chk("rst_rsp", 32'(rsp_data), 32'h00);
        chk("rst_pins", {16'd0, ui_in, uio_in}, 32'h0000);
        rst_n = 1'b1;
        #1 chk("rdy_rel", 32'(cmd_ready), 32'd1);

        send(8'h01);
        chk("ui_pre", 32'(ui_in), 32'h00);
        send(8'h5A);
        chk("ui_wr", 32'(ui_in), 32'h5A);
        chk("uio_keep", 32'(uio_in), 32'h00);
`ifdef TT_PIN_HOST_ACK_EN
        recv("ui_ack", 8'hA5, 50);
`endif

        send(8'h02);
        send(8'hC3);
        chk("uio_wr", {16'd0, ui_in, uio_in}, 32'h5AC3);
`ifdef TT_PIN_HOST_ACK_EN
        recv("uio_ack", 8'hA5, 50);
`endif

        uo_out  = 8'h12;
        uio_out = 8'h34;
        uio_oe  = 8'hF0;
        send(8'h03);
        uo_out  = 8'hAA;
        uio_out = 8'hBB;
        uio_oe  = 8'hCC;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== 8'h12) stable = 1'b0;
        end
        chk("rd_hold", 32'(stable), 32'd1);
        recv("rd_b0", 8'h12, 50);
        recv("rd_b1", 8'h34, 50);
        recv("rd_b2", 8'hF0, 50);
        @(negedge clk);
        chk("rd_done", {30'd0, rsp_valid, cmd_ready}, 32'd1);

        step_test("step3", 8'h03, 3);
        step_test("step0", 8'h00, 256);

        send(8'h05);
        send(8'h03);
        chk("ctrl", {30'd0, dut_rst_n, dut_ena}, 32'd3);
`ifdef TT_PIN_HOST_ACK_EN
        recv("ctrl_ack", 8'hA5, 50);
`endif

        send(8'h7F);
        recv("bad_op", 8'hEE, 50);
        @(negedge clk);
        chk("bad_keep", {14'd0, ui_in, uio_in, dut_rst_n, dut_ena},
            {14'd0, 8'h5A, 8'hC3, 2'b11});
        chk("bad_one", 32'(rsp_valid), 32'd0);

        send(8'h04);
        send(8'h10);
        hi_seen = 0;
        n = 0;
        while (hi_seen < 2 && n < 100) begin
            @(negedge clk);
            if (dut_clk) hi_seen++;
            n++;
        end
        chk("mid_pulse", 32'(dut_clk), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ctl", {27'd0, cmd_ready, rsp_valid, dut_clk, dut_rst_n, dut_ena}, 32'd0);
        chk("abort_rsp", 32'(rsp_data), 32'h00);
        chk("abort_pins", {16'd0, ui_in, uio_in}, 32'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p1 = pulses;
        seen = 0;
        rsp_ready = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        chk("abort_nopulse", 32'(pulses - p1), 32'd0);
        chk("abort_norsp", 32'(seen), 32'd0);
        chk("abort_rdy", 32'(cmd_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
